imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Fetch-side arbiter and sequencer for the single-ported instruction ROM. Shares the ROM fetch interface (enable, word address, combinational read data) between two requesters: port 0, the pipeline IF stage, and port 1, the debug/trace reader. Grants are issued round-robin with a per-owner burst limit. Read data is returned registered, one cycle after grant, with an alignment-error flag. The block sits between the IF stage and the ROM and drives the ROM's enable and address.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, instruction word width
- MAX_BURST, 4, maximum consecutive grants to one owner while the other port waits (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  fetch request; held until granted
- m0_addr / m1_addr  in  ADDR_W  byte address; sampled in the grant cycle
- m0_gnt / m1_gnt  out  1  combinational grant; request accepted this cycle
- m0_rvalid / m1_rvalid  out  1  registered; rdata valid, one cycle after grant
- m0_rdata / m1_rdata  out  DATA_W  registered read word
- m0_rerr / m1_rerr  out  1  registered; qualifies rvalid when the granted addr[1:0] ≠ 0
- mem_en  out  1  ROM enable (CHIP_ENABLE when either port is granted, else CHIP_DISABLE)
- mem_addr  out  ADDR_W  ROM byte address, the granted port's addr; '0 when idle
- mem_data  in  DATA_W  ROM combinational read data

## Operation
- State machine: IDLE, OWN0, OWN1; burst counter burst_cnt of width $clog2(MAX_BURST+1).
- IDLE: if only one port requests, grant it and go to its OWN state with burst_cnt=1. If both request, grant the port opposite last_owner (reset value of last_owner: port 1, so port 0 wins first).
- OWNx, owner requesting, other idle: grant owner. burst_cnt saturates at MAX_BURST.
- OWNx, owner requesting, other requesting, burst_cnt < MAX_BURST: grant owner, burst_cnt+1.
- OWNx, other requesting and (burst_cnt == MAX_BURST or owner not requesting): grant other, switch to OWNy, burst_cnt=1, last_owner=y.
- OWNx, no requests: no grant, go to IDLE, keep last_owner.
- At most one grant per cycle; gnt is never asserted without the matching req.
- Response: on grant, register mem_data into the granted port's rdata, pulse its rvalid for 1 cycle, and set rerr = |addr[1:0]. The other port's rvalid/rerr are 0. rdata holds its last value when rvalid is low.
- Misaligned requests are still sent to the ROM; the word is returned with rerr=1.

## Timing
- Grant latency: 0 cycles when uncontended; under contention the wait is bounded by MAX_BURST cycles.
- Data latency: rvalid/rdata 1 cycle after the gnt cycle; back-to-back grants give one word per cycle.
- Reset values: state=IDLE, burst_cnt=0, last_owner=1, all rvalid=0, rerr=0, rdata='0; mem_en=CHIP_DISABLE and mem_addr='0 while no grant.
- Reset asserted mid-burst: the cycle after reset, no rvalid is produced for a grant issued in the reset cycle. Grants are suppressed while rst=1.
- A request dropped before grant is simply not served; no pending state is kept.

## Structure
- Shared package (project_types): CHIP_ENABLE/CHIP_DISABLE, inst_addr_t, inst_data_t (already present); add an imem_owner_e enum (OWNER_IF, OWNER_DBG) and the arbiter state enum.
- Optional sub-module rr_burst_grant: the pure next-grant and next-state logic (combinational), instantiated once. The response registers stay in the top level.
- The ROM side connects to the existing i_fetch_inst interface through its master modport.

## Test plan
- Reset then idle: rst=1 for 2 cycles → all rvalid=0, mem_en=CHIP_DISABLE, mem_addr=0. Release with no requests → outputs unchanged.
- Single requester: m0_req held, addr 0x0, 0x4, 0x8 on successive cycles → m0_gnt each cycle; m0_rvalid in cycles +1..+3 with rdata = ROM words 0, 1, 2; m1 outputs quiet.
- Contention, MAX_BURST=4: both requesting continuously from IDLE → grant pattern 0,0,0,0,1,1,1,1,0…; no cycle without a grant.
- Early yield: m0 owner drops req after 2 grants while m1 waits → m1 granted on the next cycle, burst_cnt=1.
- Misaligned: m1 addr 0x6 → m1_rvalid=1, m1_rerr=1, rdata = ROM word 1.
- Reset mid-burst: rst asserted on the 3rd grant cycle → no rvalid the next cycle; after release, m0 wins first arbitration against m1.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-fetch arbiter: chip-enable levels, fetch
// word types, owner encoding and the arbiter state machine encoding.
package imem_arbiter_pkg;

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   typedef logic [31:0] inst_addr_t;
   typedef logic [31:0] inst_data_t;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_DBG = 1'b1
   } imem_owner_e;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_e;

   function automatic imem_owner_e other_owner(input imem_owner_e o);
      return (o == OWNER_IF) ? OWNER_DBG : OWNER_IF;
   endfunction

   function automatic arb_state_e own_state(input imem_owner_e o);
      return (o == OWNER_IF) ? ARB_OWN0 : ARB_OWN1;
   endfunction

endpackage

// File: rtl/imem_arbiter_rr_burst_grant.sv
// Pure combinational grant decision: round-robin between the two fetch ports
// with a per-owner burst limit, plus the next arbiter state.
module rr_burst_grant
   import imem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  arb_state_e        state,
   input  logic [CNT_W-1:0]  burst_cnt,
   input  imem_owner_e       last_owner,
   output logic              gnt0,
   output logic              gnt1,
   output arb_state_e        state_nxt,
   output logic [CNT_W-1:0]  burst_cnt_nxt,
   output imem_owner_e       last_owner_nxt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic        grant;
   imem_owner_e pick;
   imem_owner_e owner;
   logic        owner_req;
   logic        other_req;

   // NOTE: every output of this always_comb gets a default on entry; a path
   // that skips an assignment would otherwise infer a latch.
   always_comb begin
      grant          = 1'b0;
      pick           = last_owner;
      state_nxt      = ARB_IDLE;
      burst_cnt_nxt  = '0;
      last_owner_nxt = last_owner;
      owner          = (state == ARB_OWN1) ? OWNER_DBG : OWNER_IF;
      owner_req      = (owner == OWNER_IF) ? req0 : req1;
      other_req      = (owner == OWNER_IF) ? req1 : req0;

      case (state)
         ARB_IDLE: begin
            if (req0 && req1) begin
               grant = 1'b1;
               pick  = other_owner(last_owner);
            end else if (req0) begin
               grant = 1'b1;
               pick  = OWNER_IF;
            end else if (req1) begin
               grant = 1'b1;
               pick  = OWNER_DBG;
            end
         end
         default: begin
            // Hand over when the waiting port has been held off long enough
            // or the owner has stopped asking.
            if (other_req && (!owner_req || burst_cnt == CNT_MAX)) begin
               grant = 1'b1;
               pick  = other_owner(owner);
            end else if (owner_req) begin
               grant = 1'b1;
               pick  = owner;
            end
         end
      endcase

      if (rst) begin
         grant = 1'b0;
      end

      if (grant) begin
         last_owner_nxt = pick;
         state_nxt      = own_state(pick);
         if (state != own_state(pick)) begin
            burst_cnt_nxt = CNT_ONE;
         end else if (burst_cnt != CNT_MAX) begin
            burst_cnt_nxt = burst_cnt + CNT_ONE;
         end else begin
            burst_cnt_nxt = burst_cnt;
         end
      end
   end

   assign gnt0 = grant && (pick == OWNER_IF);
   assign gnt1 = grant && (pick == OWNER_DBG);

endmodule

// File: rtl/imem_arbiter.sv
// Instruction ROM fetch arbiter: shares one combinational-read ROM between the
// IF stage (port 0) and the debug/trace reader (port 1), registered responses.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = $bits(inst_addr_t),
   parameter int DATA_W    = $bits(inst_data_t),
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_rerr,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_rerr,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e       state, state_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
   imem_owner_e      last_owner, last_owner_nxt;

   rr_burst_grant #(
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) u_grant (
      .rst            (rst),
      .req0           (m0_req),
      .req1           (m1_req),
      .state          (state),
      .burst_cnt      (burst_cnt),
      .last_owner     (last_owner),
      .gnt0           (m0_gnt),
      .gnt1           (m1_gnt),
      .state_nxt      (state_nxt),
      .burst_cnt_nxt  (burst_cnt_nxt),
      .last_owner_nxt (last_owner_nxt)
   );

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         burst_cnt  <= '0;
         last_owner <= OWNER_DBG;
      end else begin
         state      <= state_nxt;
         burst_cnt  <= burst_cnt_nxt;
         last_owner <= last_owner_nxt;
      end
   end

   assign mem_en   = (m0_gnt || m1_gnt) ? CHIP_ENABLE : CHIP_DISABLE;
   assign mem_addr = m0_gnt ? m0_addr : (m1_gnt ? m1_addr : '0);

   // rdata words are cleared on reset and otherwise only load on a grant,
   // so they hold the last fetched word between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rerr   <= 1'b0;
         m1_rerr   <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_rvalid <= m0_gnt;
         m1_rvalid <= m1_gnt;
         m0_rerr   <= m0_gnt && (|m0_addr[1:0]);
         m1_rerr   <= m1_gnt && (|m1_addr[1:0]);
         if (m0_gnt) begin
            m0_rdata <= mem_data;
         end
         if (m1_gnt) begin
            m1_rdata <= mem_data;
         end
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized
// traffic against a behavioural round-robin/burst model.
module tb_imem_arbiter;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_BURST = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_req, m1_req;
   logic [ADDR_W-1:0] m0_addr, m1_addr;
   logic              m0_gnt, m1_gnt;
   logic              m0_rvalid, m1_rvalid;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic              m0_rerr, m1_rerr;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000_0000 ^ ((a >> 2) * 32'h0101_0103);
   endfunction

   assign mem_data = rom_word(mem_addr);

   imem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_addr   (m0_addr),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m0_rerr   (m0_rerr),
      .m1_req    (m1_req),
      .m1_addr   (m1_addr),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .m1_rerr   (m1_rerr),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data)
   );

   // Reference model: who owns the ROM (-1 none), how many grants in a row,
   // who was granted last, and the response expected after the next edge.
   int          m_owner = -1;
   int          m_run   = 0;
   int          m_last  = 1;
   logic [1:0]  e_rv    = 2'b00;
   logic [1:0]  e_re    = 2'b00;
   logic [31:0] e_rd0   = '0;
   logic [31:0] e_rd1   = '0;

   function automatic int model_grant(input logic r, input logic q0, input logic q1);
      if (r || (!q0 && !q1)) return -1;
      if (q0 && q1) begin
         if (m_owner < 0) return 1 - m_last;
         if (m_run < MAX_BURST) return m_owner;
         return 1 - m_owner;
      end
      return q0 ? 0 : 1;
   endfunction

   // One clock: drive inputs, check combinational and registered outputs
   // mid-cycle, advance the model, then move to 1ns past the next edge.
   task automatic step(input logic r, input logic q0, input logic q1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       output int og);
      int          g;
      logic [31:0] ga;
      rst = r; m0_req = q0; m1_req = q1; m0_addr = a0; m1_addr = a1;
      #4;
      g  = model_grant(r, q0, q1);
      ga = (g == 0) ? a0 : ((g == 1) ? a1 : 32'h0);
      og = m0_gnt ? 0 : (m1_gnt ? 1 : -1);

      n_vec++;
      if ({m1_gnt, m0_gnt} !== {g == 1, g == 0}) begin
         n_err++;
         $display("FAIL grant @%0t: got m1/m0=%b%b expected %b%b", $time, m1_gnt, m0_gnt, g == 1, g == 0);
      end
      n_vec++;
      if (mem_en !== (g >= 0) || mem_addr !== ga) begin
         n_err++;
         $display("FAIL mem_port @%0t: got en=%b addr=%h expected en=%b addr=%h", $time, mem_en, mem_addr, g >= 0, ga);
      end
      n_vec++;
      if ({m1_rvalid, m0_rvalid} !== e_rv || {m1_rerr, m0_rerr} !== e_re) begin
         n_err++;
         $display("FAIL rvalid_rerr @%0t: got rv=%b%b re=%b%b expected rv=%b re=%b", $time, m1_rvalid, m0_rvalid, m1_rerr, m0_rerr, e_rv, e_re);
      end
      n_vec++;
      if (m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
         n_err++;
         $display("FAIL rdata @%0t: got %h/%h expected %h/%h", $time, m0_rdata, m1_rdata, e_rd0, e_rd1);
      end

      if (r) begin
         m_owner = -1; m_run = 0; m_last = 1;
         e_rv = 2'b00; e_re = 2'b00; e_rd0 = '0; e_rd1 = '0;
      end else begin
         e_rv = {g == 1, g == 0};
         e_re = 2'b00;
         if (g >= 0) begin
            e_re[g] = |ga[1:0];
            if (g == 0) e_rd0 = rom_word(ga);
            else        e_rd1 = rom_word(ga);
            m_run   = (g == m_owner) ? ((m_run < MAX_BURST) ? m_run + 1 : MAX_BURST) : 1;
            m_owner = g;
            m_last  = g;
         end else begin
            m_owner = -1;
            m_run   = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int og;
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, og);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, og);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, og);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, og);
      n_vec++;
      if (og !== -1 || mem_addr !== 32'h0) begin
         n_err++;
         $display("FAIL reset_idle: got grant=%0d addr=%h expected -1/0", og, mem_addr);
      end
   endtask

   task automatic test_single();
      int og;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'(4 * i), 32'h0, og);
         n_vec++;
         if (og !== 0) begin
            n_err++;
            $display("FAIL single_gnt[%0d]: got %0d expected 0", i, og);
         end
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, og);
      n_vec++;
      if (m0_rdata !== rom_word(32'h8) || m1_rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL single_last_word: got %h m1_rvalid=%b expected %h 0", m0_rdata, m1_rvalid, rom_word(32'h8));
      end
   endtask

   task automatic test_contention();
      int og;
      int pat[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, og);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, 1'b1, 32'(16 * i), 32'(16 * i + 4), og);
         n_vec++;
         if (og !== pat[i]) begin
            n_err++;
            $display("FAIL contention[%0d]: got %0d expected %0d", i, og, pat[i]);
         end
      end
   endtask

   task automatic test_early_yield();
      int og;
      int pat[4] = '{1, 1, 1, 0};
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, og);
      step(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, og);
      step(1'b0, 1'b1, 1'b1, 32'h24, 32'h40, og);
      step(1'b0, 1'b0, 1'b1, 32'h0, 32'h40, og);
      n_vec++;
      if (og !== 1) begin
         n_err++;
         $display("FAIL early_yield: got %0d expected 1", og);
      end
      // New owner starts a fresh burst: three more grants before handing back.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b1, 32'h28, 32'(32'h44 + 4 * i), og);
         n_vec++;
         if (og !== pat[i]) begin
            n_err++;
            $display("FAIL yield_burst[%0d]: got %0d expected %0d", i, og, pat[i]);
         end
      end
   endtask

   task automatic test_misaligned();
      int og;
      step(1'b0, 1'b0, 1'b1, 32'h0, 32'h6, og);
      n_vec++;
      if (m1_rvalid !== 1'b1 || m1_rerr !== 1'b1 || m1_rdata !== rom_word(32'h4)) begin
         n_err++;
         $display("FAIL misaligned: got rv=%b re=%b data=%h expected 1 1 %h", m1_rvalid, m1_rerr, m1_rdata, rom_word(32'h4));
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, og);
   endtask

   task automatic test_reset_mid_burst();
      int og;
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, og);
      step(1'b0, 1'b1, 1'b1, 32'h0, 32'h4, og);
      step(1'b0, 1'b1, 1'b1, 32'h4, 32'h4, og);
      step(1'b1, 1'b1, 1'b1, 32'h8, 32'h4, og);
      n_vec++;
      if (og !== -1) begin
         n_err++;
         $display("FAIL reset_gnt_suppress: got %0d expected -1", og);
      end
      n_vec++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_no_rvalid: got %b%b expected 00", m1_rvalid, m0_rvalid);
      end
      step(1'b0, 1'b1, 1'b1, 32'hC, 32'h4, og);
      n_vec++;
      if (og !== 0) begin
         n_err++;
         $display("FAIL reset_first_arb: got %0d expected 0", og);
      end
   endtask

   task automatic test_random();
      int og;
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 39) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0,
              32'($urandom_range(0, 255)),
              32'($urandom_range(0, 255)),
              og);
      end
   endtask

   initial begin
      rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_contention();
      test_early_yield();
      test_misaligned();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
